// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver: configuration, serial line, FIFO push and status.
// master drives the receiver configuration and line; slave is the receiver engine.
interface uart_rx_if #(
    parameter int DIV_WIDTH = 16
);
    logic                 enable;
    logic [DIV_WIDTH-1:0] clk_div;
    logic                 uart_rx;
    logic                 fifo_full;
    logic                 err_clear;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 busy;

    modport master (
        output enable, clk_div, uart_rx, fifo_full, err_clear,
        input  rx_data, rx_valid, frame_err, overrun_err, busy
    );

    modport slave (
        input  enable, clk_div, uart_rx, fifo_full, err_clear,
        output rx_data, rx_valid, frame_err, overrun_err, busy
    );
endinterface

// File: rtl/uart_rx_engine.sv
// 8N1 LSB-first UART receiver: synchronises the line, validates the start bit at mid-bit,
// samples each data/stop bit at its centre and pushes good bytes with a one-cycle strobe.
module uart_rx_engine #(
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(4);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_err_q, overrun_err_d;

    logic                   rxs;
    logic                   fall;
    logic                   cnt_zero;
    logic [DIV_WIDTH-1:0]   div_eff;

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign fall     = prev_q & ~rxs;
    assign cnt_zero = (cnt_q == '0);
    assign div_eff  = (bus.clk_div < MIN_DIV) ? MIN_DIV : bus.clk_div;

    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], bus.uart_rx};
        prev_d        = rxs;
        state_d       = state_q;
        cnt_d         = cnt_q;
        div_d         = div_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_err_d   = frame_err_q;
        overrun_err_d = overrun_err_q;

        // Clear first so that an error detected in the same cycle still sets the flag.
        if (bus.err_clear) begin
            frame_err_d   = 1'b0;
            overrun_err_d = 1'b0;
        end

        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        div_d   = div_eff;
                        cnt_d   = (div_eff >> 1) - ONE;
                        state_d = START;
                    end
                end
                START: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - ONE;
                    end else if (!rxs) begin
                        cnt_d     = div_q - ONE;
                        bit_idx_d = 3'd0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - ONE;
                    end else begin
                        shift_d   = {rxs, shift_q[7:1]};
                        cnt_d     = div_q - ONE;
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_d = STOP;
                    end
                end
                STOP: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - ONE;
                    end else begin
                        state_d = IDLE;
                        if (!rxs)               frame_err_d   = 1'b1;
                        else if (bus.fifo_full) overrun_err_d = 1'b1;
                        else begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Synchroniser and previous-line flop reset to the idle-high line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sync_q        <= '1;
            prev_q        <= 1'b1;
            cnt_q         <= '0;
            div_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.overrun_err = overrun_err_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: a table of 8N1 frames at 16 clocks/bit plus
// hand-written sequences for glitch, clamped back-to-back, reset and disable mid-frame.
module tb_uart_rx_engine;
    localparam int DIV_WIDTH   = 16;
    localparam int SYNC_STAGES = 2;

    logic clk;
    logic reset;

    uart_rx_if #(.DIV_WIDTH(DIV_WIDTH)) bus ();

    uart_rx_engine #(.DIV_WIDTH(DIV_WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe seen is logged with the cycle it was observed in.
    logic [7:0] got_q[$];
    int         n_valid = 0;
    int         last_valid_cyc = 0;
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            got_q.push_back(bus.rx_data);
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int fall_cyc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Drives one 8N1 frame starting at a negedge, bitc clocks per bit, then idle cycles high.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int bitc, input int idle);
        fall_cyc    = cyc;
        bus.uart_rx = 1'b0;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = d[i];
            repeat (bitc) @(negedge clk);
        end
        bus.uart_rx = stop;
        repeat (bitc) @(negedge clk);
        bus.uart_rx = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    task automatic pulse_clear();
        bus.err_clear = 1'b1;
        @(negedge clk);
        bus.err_clear = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic       clr;
        logic [7:0] data;
        logic       stop;
        logic       full;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_oe;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n0;
        int lat_exp;
        logic [7:0] held;
        bit done;

        vecs[0] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'h66, 1'b1, 1'b0, 1'b1, 8'h66, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};

        reset         = 1'b1;
        bus.enable    = 1'b1;
        bus.clk_div   = 16'd16;
        bus.uart_rx   = 1'b1;
        bus.fifo_full = 1'b0;
        bus.err_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("reset rx_data", {24'd0, bus.rx_data}, 32'h0);
        check("reset rx_valid", {31'd0, bus.rx_valid}, 32'h0);
        check("reset flags", {30'd0, bus.frame_err, bus.overrun_err}, 32'h0);
        check("reset busy", {31'd0, bus.busy}, 32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Glitch: start bit shorter than half a bit is rejected at the mid-bit check.
        n0          = n_valid;
        fall_cyc    = cyc;
        bus.uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.uart_rx = 1'b1;
        check("glitch busy rose", {31'd0, bus.busy}, 32'h1);
        done = 1'b0;
        while (!done && (cyc - fall_cyc) <= 12) begin
            if (bus.busy === 1'b0) done = 1'b1;
            else @(negedge clk);
        end
        check("glitch busy low within 12", {31'd0, done}, 32'h1);
        repeat (20) @(negedge clk);
        check("glitch no valid", n_valid - n0, 0);
        check("glitch no flags", {30'd0, bus.frame_err, bus.overrun_err}, 32'h0);

        // Stop bit sampled at its centre: 9.5 bit periods after the synchronised edge.
        lat_exp = SYNC_STAGES + 16 / 2 + 9 * 16 + 1;
        held    = 8'h00;
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].clr) pulse_clear();
            bus.fifo_full = vecs[v].full;
            n0 = n_valid;
            send_frame(vecs[v].data, vecs[v].stop, 16, 32);
            bus.fifo_full = 1'b0;
            check($sformatf("vec%0d valid count", v), n_valid - n0, {31'd0, vecs[v].exp_valid});
            if (vecs[v].exp_valid) begin
                held = vecs[v].exp_data;
                check($sformatf("vec%0d data", v), {24'd0, got_q[$]}, {24'd0, held});
                check($sformatf("vec%0d latency ok", v),
                      {31'd0, ((last_valid_cyc - fall_cyc) >= lat_exp - 1) &&
                              ((last_valid_cyc - fall_cyc) <= lat_exp + 1)}, 32'h1);
            end
            check($sformatf("vec%0d rx_data held", v), {24'd0, bus.rx_data}, {24'd0, held});
            check($sformatf("vec%0d frame_err", v), {31'd0, bus.frame_err}, {31'd0, vecs[v].exp_fe});
            check($sformatf("vec%0d overrun_err", v), {31'd0, bus.overrun_err}, {31'd0, vecs[v].exp_oe});
            check($sformatf("vec%0d busy idle", v), {31'd0, bus.busy}, 32'h0);
        end

        // clk_div below the minimum clamps to 4; frames back to back with one stop bit.
        bus.clk_div = 16'd2;
        n0 = n_valid;
        send_frame(8'h00, 1'b1, 4, 0);
        send_frame(8'hFF, 1'b1, 4, 16);
        check("b2b count", n_valid - n0, 2);
        if (n_valid - n0 == 2) begin
            check("b2b first", {24'd0, got_q[got_q.size()-2]}, 32'h00);
            check("b2b second", {24'd0, got_q[got_q.size()-1]}, 32'hFF);
        end
        bus.clk_div = 16'd16;

        // Reset asserted in the middle of data bit 4 of 0x81.
        bus.uart_rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.uart_rx = (i == 0);
            repeat (16) @(negedge clk);
        end
        bus.uart_rx = 1'b0;
        repeat (8) @(negedge clk);
        check("pre-reset busy", {31'd0, bus.busy}, 32'h1);
        reset       = 1'b1;
        bus.uart_rx = 1'b1;
        #1;
        check("mid reset rx_data", {24'd0, bus.rx_data}, 32'h0);
        check("mid reset rx_valid", {31'd0, bus.rx_valid}, 32'h0);
        check("mid reset flags", {30'd0, bus.frame_err, bus.overrun_err}, 32'h0);
        check("mid reset busy", {31'd0, bus.busy}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Disable mid-frame, finish the frame with the receiver off, then a clean 0x81.
        n0 = n_valid;
        bus.uart_rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = (i == 0) || (i == 7);
            if (i == 4) begin
                repeat (8) @(negedge clk);
                bus.enable = 1'b0;
                @(negedge clk);
                check("disable busy", {31'd0, bus.busy}, 32'h0);
                repeat (7) @(negedge clk);
            end else begin
                repeat (16) @(negedge clk);
            end
        end
        bus.uart_rx = 1'b1;
        repeat (32) @(negedge clk);
        check("disable no valid", n_valid - n0, 0);
        bus.enable = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h81, 1'b1, 16, 32);
        check("after disable count", n_valid - n0, 1);
        check("after disable data", {24'd0, bus.rx_data}, 32'h81);
        check("after disable flags", {30'd0, bus.frame_err, bus.overrun_err}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
